// File: rtl/tweezer_dac_pkg.sv
// Shared types and constants for the tweezer DAC SPI transmitter.
// Optional LDAC pulse stage is enabled with TWEEZER_DAC_LDAC_EN.
package tweezer_dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_LDAC,
    S_GAP
  } state_t;

  localparam int OVR_W = 16;

  function automatic int frame_width(input int cmd_bits, input int data_bits);
    return cmd_bits + data_bits;
  endfunction

endpackage

// File: rtl/tweezer_dac_sclk_gen.sv
// SCLK divider: while enabled, holds each phase for sclkHalfDiv cycles and
// flags the last cycle of the high phase (fall tick) and of the low phase (rise tick).
module tweezer_dac_sclk_gen #(
  parameter int sclkHalfDiv = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int DIV_W = $clog2(sclkHalfDiv + 1);

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             w_tick;

  assign w_tick = i_en && (r_div == DIV_W'(sclkHalfDiv - 1));

  // Phase is preset high so the first enabled cycle already drives SCLK high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_phase <= 1'b1;
    end else if (!i_en) begin
      r_div   <= '0;
      r_phase <= 1'b1;
    end else if (w_tick) begin
      r_div   <= '0;
      r_phase <= !r_phase;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

  assign o_sclk      = i_en && r_phase;
  assign o_rise_tick = w_tick && !r_phase;
  assign o_fall_tick = w_tick && r_phase;

endmodule

// File: rtl/tweezer_dac_spi_tx.sv
// Serializes the newest controller sample to the actuator DAC (SPI mode 0, MSB first).
// Define TWEEZER_DAC_LDAC_EN to pulse ldac_n low after every frame.
module tweezer_dac_spi_tx
  import tweezer_dac_pkg::*;
#(
  parameter int                    dataBitSize  = 16,
  parameter int                    cmdBitSize   = 8,
  parameter logic [cmdBitSize-1:0] cmdWord      = 8'h30,
  parameter int                    sclkHalfDiv  = 4,
  parameter int                    csSetup      = 2,
  parameter int                    csHold       = 2,
  parameter int                    csIdle       = 4,
  parameter bit                    offsetBinary = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [dataBitSize-1:0] data,
  input  logic                   data_valid,
  output logic                   sclk,
  output logic                   cs_n,
  output logic                   mosi,
  output logic                   ldac_n,
  output logic                   busy,
  output logic                   frame_done,
  output logic [OVR_W-1:0]       overrun_cnt,
  output state_t                 o_dbg_state
);

  localparam int FW    = frame_width(cmdBitSize, dataBitSize);
  localparam int BIT_W = $clog2(FW + 1);
  localparam logic [dataBitSize-1:0] FLIP =
    offsetBinary ? {1'b1, {(dataBitSize-1){1'b0}}} : '0;

  state_t             r_state, w_state_next;
  logic [15:0]        r_cnt;
  logic               w_cnt_clr;
  logic               w_consume;
  logic [BIT_W-1:0]   r_bits;
  logic [FW-1:0]      r_shift;
  logic [dataBitSize-1:0] r_slot;
  logic               r_full;
  logic [OVR_W-1:0]   r_ovr;
  logic               w_rise_tick, w_fall_tick, w_sclk;

  tweezer_dac_sclk_gen #(.sclkHalfDiv(sclkHalfDiv)) u_sclk_gen (
    .clk         (clk),
    .reset       (reset),
    .i_en        (r_state == S_SHIFT),
    .o_sclk      (w_sclk),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      S_IDLE: if (r_full) begin
        w_state_next = S_SETUP;
        w_consume    = 1'b1;
        w_cnt_clr    = 1'b1;
      end
      S_SETUP: if (r_cnt == 16'(csSetup - 1)) begin
        w_state_next = S_SHIFT;
        w_cnt_clr    = 1'b1;
      end
      // Leave on the rise tick after the last fall so the final low half completes.
      S_SHIFT: if (w_rise_tick && (r_bits == BIT_W'(FW))) begin
        w_state_next = S_HOLD;
        w_cnt_clr    = 1'b1;
      end
      S_HOLD: if (r_cnt == 16'(csHold - 1)) begin
`ifdef TWEEZER_DAC_LDAC_EN
        w_state_next = S_LDAC;
`else
        w_state_next = S_GAP;
`endif
        w_cnt_clr    = 1'b1;
      end
      S_LDAC: if (r_cnt == 16'(sclkHalfDiv)) begin
        w_state_next = S_GAP;
        w_cnt_clr    = 1'b1;
      end
      S_GAP: if (r_cnt == 16'(csIdle - 1)) begin
        w_state_next = S_IDLE;
        w_cnt_clr    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
    end
  end

  // A load in the consume cycle overwrites nothing still unsent, so it stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
      r_full <= 1'b0;
      r_ovr  <= '0;
    end else if (data_valid) begin
      r_slot <= data;
      r_full <= 1'b1;
      if (r_full && !w_consume && (r_ovr != '1)) r_ovr <= r_ovr + 1'b1;
    end else if (w_consume) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_bits  <= '0;
    end else if (w_consume) begin
      r_shift <= {cmdWord, r_slot ^ FLIP};
      r_bits  <= '0;
    end else if (w_fall_tick) begin
      r_bits <= r_bits + 1'b1;
      if (r_bits != BIT_W'(FW - 1)) r_shift <= {r_shift[FW-2:0], 1'b0};
    end
  end

  assign sclk        = w_sclk;
  assign cs_n        = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
  assign mosi        = r_shift[FW-1];
  assign busy        = (r_state != S_IDLE);
  assign overrun_cnt = r_ovr;
  assign o_dbg_state = r_state;
`ifdef TWEEZER_DAC_LDAC_EN
  assign frame_done  = (r_state == S_LDAC) && (r_cnt == 16'd0);
  assign ldac_n      = !((r_state == S_LDAC) && (r_cnt != 16'd0));
`else
  assign frame_done  = (r_state == S_GAP) && (r_cnt == 16'd0);
  assign ldac_n      = 1'b1;
`endif

endmodule

// File: tb/tb_tweezer_dac_spi_tx.sv
// Bench for tweezer_dac_spi_tx: timeline model of the frame, per-cycle compare,
// plus directed literal checks (also usable with TWEEZER_DAC_LDAC_EN defined).
`timescale 1ns/1ps
module tb_tweezer_dac_spi_tx;
  import tweezer_dac_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 8;
  localparam int H   = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSI = 4;
  localparam int FW  = CW + DW;
  localparam int T   = CSS + FW * 2 * H + CSH;
`ifdef TWEEZER_DAC_LDAC_EN
  localparam int P   = 1 + H + CSI;
  localparam bit LDAC = 1'b1;
`else
  localparam int P   = CSI;
  localparam bit LDAC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic sclk, cs_n, mosi, ldac_n, busy, frame_done;
  logic [15:0] overrun_cnt;
  state_t dbg_state;

  logic [DW-1:0] f_data = '0;
  logic          f_valid = 1'b0;
  logic f_sclk, f_cs_n, f_mosi, f_ldac_n, f_busy, f_done;
  logic [15:0] f_ovr;
  state_t f_state;

  tweezer_dac_spi_tx u_dut (
    .clk(clk), .reset(rst), .data(data), .data_valid(data_valid),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .ldac_n(ldac_n), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .o_dbg_state(dbg_state)
  );

  tweezer_dac_spi_tx #(.sclkHalfDiv(1), .csSetup(1), .csHold(1), .csIdle(1)) u_fast (
    .clk(clk), .reset(rst), .data(f_data), .data_valid(f_valid),
    .sclk(f_sclk), .cs_n(f_cs_n), .mosi(f_mosi), .ldac_n(f_ldac_n), .busy(f_busy),
    .frame_done(f_done), .overrun_cnt(f_ovr), .o_dbg_state(f_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cap_q[$];
  int            low_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_full = 1'b0;
  logic [DW-1:0] m_slot = '0;
  logic [15:0]   m_ovr = '0;
  bit            m_act = 1'b0;
  int            m_k = 0;
  logic [FW-1:0] m_frame = '0;
  int            n_consume = 0;
  logic [FW-1:0] cap = '0;
  int            lowc = 0;
  logic          prev_sclk = 1'b0;

  always @(negedge clk) begin
    logic e_cs, e_busy, e_done, e_ldac, e_sclk;
    int   s, idx;
    bit   consume;
    if (rst) begin
      m_full = 1'b0; m_ovr = '0; m_act = 1'b0; m_k = 0;
      cap = '0; lowc = 0;
    end
    e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ldac = 1'b1; e_sclk = 1'b0;
    if (m_act) begin
      s      = m_k - CSS;
      e_cs   = !(m_k < T);
      e_busy = 1'b1;
      e_done = (m_k == T);
      e_ldac = !(LDAC && (m_k > T) && (m_k <= T + H));
      e_sclk = (s >= 0) && (s < FW * 2 * H) && ((s % (2 * H)) < H);
    end
    chk("cs_n", cs_n, e_cs);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    chk("ldac_n", ldac_n, e_ldac);
    chk("sclk", sclk, e_sclk);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    if (m_act && (m_k < T)) begin
      idx = (m_k < CSS + H) ? 0 : ((m_k - CSS - H) / (2 * H) + 1);
      if (idx > FW - 1) idx = FW - 1;
      chk("mosi", mosi, m_frame[FW-1-idx]);
    end
    if (!rst) begin
      if (sclk && !prev_sclk) cap = {cap[FW-2:0], mosi};
      if (!cs_n) lowc++;
      if (frame_done) begin
        cap_q.push_back(cap);
        low_q.push_back(lowc);
        if (exp_q.size() != 0) chk("frame_vs_model", cap, exp_q.pop_front());
        cap = '0; lowc = 0;
      end
      consume = !m_act && m_full;
      if (consume) begin
        m_frame = {8'h30, m_slot ^ 16'h8000};
        exp_q.push_back(m_frame);
        n_consume++;
      end
      if (data_valid) begin
        if (m_full && !consume && (m_ovr != 16'hFFFF)) m_ovr++;
        m_slot = data;
        m_full = 1'b1;
      end else if (consume) begin
        m_full = 1'b0;
      end
      if (consume) begin
        m_act = 1'b1; m_k = 0;
      end else if (m_act) begin
        m_k++;
        if (m_k == T + P) m_act = 1'b0;
      end
    end else begin
      exp_q.delete();
    end
    prev_sclk = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    data = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_frame(output logic [FW-1:0] f, output int lc);
    int n = 0;
    while (cap_q.size() == 0 && n < 1000) begin tick(); n++; end
    checks++;
    if (cap_q.size() == 0) begin
      errors++;
      $display("FAIL frame_wait: no frame after %0d cycles, required one", n);
      f = '0; lc = 0;
    end else begin
      f = cap_q.pop_front();
      lc = low_q.pop_front();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_act || m_full) && n < 2000) begin tick(); n++; end
    checks++;
    if (busy || m_act || m_full) begin
      errors++;
      $display("FAIL idle_wait: busy=%0d after %0d cycles, required 0", busy, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] last;
    int lc, c0, consumed, n, lat, done_n;
    logic prev;

    repeat (3) tick();
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_ldac_n", ldac_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_state_idle", dbg_state == S_IDLE, 1);
    rst = 1'b0;
    repeat (2) tick();

    // single sample, two's complement 0x8001 -> offset binary 0x0001
    send(16'h8001);
    wait_frame(f, lc);
    chk("t1_frame", f, 24'h300001);
    chk("t1_cs_low_cycles", lc, 196);
    chk("t1_overrun", overrun_cnt, 0);
    wait_idle();
    chk("t1_single_done", cap_q.size(), 0);

    // three valids during a frame: the last one wins, two overruns
    send(16'h1234);
    repeat (20) tick();
    send(16'h0A0A);
    repeat (5) tick();
    send(16'h0B0B);
    tick();
    send(16'hFFFE);
    wait_frame(f, lc);
    chk("t3_first", f, 24'h309234);
    wait_frame(f, lc);
    chk("t3_newest", f, 24'h307FFE);
    chk("t3_overrun", overrun_cnt, 2);
    wait_idle();

    // valid every cycle for 600 cycles, incrementing data
    c0 = n_consume;
    for (int i = 0; i < 600; i++) begin
      data = DW'(i);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    wait_idle();
    consumed = n_consume - c0;
    chk("t2_overrun", overrun_cnt, 2 + 600 - consumed);
    chk("t2_frame_count", cap_q.size(), consumed);
    last = '0;
    while (cap_q.size() != 0) begin
      last = cap_q.pop_front();
      void'(low_q.pop_front());
    end
    chk("t2_last_frame", last, 24'h308257);

    // random sparse traffic
    for (int i = 0; i < 1500; i++) begin
      data = DW'($urandom);
      data_valid = ($urandom_range(0, 7) == 0);
      tick();
    end
    data_valid = 1'b0;
    wait_idle();
    cap_q.delete();
    low_q.delete();

    // asynchronous reset at bit 10 of a frame
    send(16'h4321);
    n = 0;
    while (!(m_act && m_k == CSS + 10 * 2 * H) && n < 500) begin tick(); n++; end
    chk("t4_reached_bit10", m_act && (m_k == CSS + 10 * 2 * H), 1);
    chk("t4_pre_sclk", sclk, 1);
    rst = 1'b1;
    #1;
    chk("t4_cs_n", cs_n, 1);
    chk("t4_sclk", sclk, 0);
    chk("t4_busy", busy, 0);
    chk("t4_mosi", mosi, 0);
    chk("t4_overrun", overrun_cnt, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("t4_no_stale_frame", cap_q.size(), 0);
    send(16'h0055);
    wait_frame(f, lc);
    chk("t4_new_frame", f, 24'h308055);
    chk("t4_cs_low_cycles", lc, 196);
    wait_idle();

    // fast configuration: half=1, setup=hold=idle=1
    f_data = 16'h7FFF;
    f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    n = 0; lc = 0; lat = 0; done_n = 0; f = '0; prev = 1'b0;
    while (n < 200 && lat == 0) begin
      @(negedge clk);
      n++;
      if (f_sclk && !prev) f = {f[FW-2:0], f_mosi};
      prev = f_sclk;
      if (!f_cs_n) lc++;
      else if (lc != 0) lat = n;
      if (f_done) done_n++;
    end
    chk("t6_frame", f, 24'h30FFFF);
    chk("t6_cs_low_cycles", lc, 50);
    chk("t6_latency", lat - 1, 51);
    chk("t6_frame_done", done_n, 1);
    repeat (10) tick();
    chk("t6_overrun", f_ovr, 0);
    chk("t6_idle_busy", f_busy, 0);
    chk("t6_idle_state", f_state == S_IDLE, 1);
    chk("t6_ldac_idle", f_ldac_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
